pipeline_ctrl: RTL and testbench

- Central pipeline-control unit. It is the producer side of the stall[5:0]/flush interface that every inter-stage register (pc_reg, if_id, id_ex, ex_mem, mem_wb) consumes.
- Arbitrates stall requests from the IF, ID, EX and MEM stages. Turns MEM-stage exception types into a one-cycle flush plus a redirect PC.
- Tracks pipeline health with sequential state: post-flush FSM, stall watchdog, and performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 56 +++++
 rtl/pipeline_ctrl_if.sv | 25 ++
 rtl/pipeline_ctrl_stall_watchdog.sv | 38 +++
 rtl/pipeline_ctrl.sv | 111 +++++++++++
 tb/tb_pipeline_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: exception codes, stall masks,
// FSM encoding and the stall/redirect decode helpers.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALLED = 2'd1,
        ST_FLUSHED = 2'd2
    } ctrl_state_e;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    // The deepest requesting stage wins; it holds itself and everything upstream.
    function automatic logic [5:0] stall_arbitrate(input logic req_if, input logic req_id,
                                                   input logic req_ex, input logic req_mem);
        logic [5:0] mask;
        if (req_mem) begin
            mask = STALL_MEM;
        end else if (req_ex) begin
            mask = STALL_EX;
        end else if (req_id) begin
            mask = STALL_ID;
        end else if (req_if) begin
            mask = STALL_IF;
        end else begin
            mask = STALL_NONE;
        end
        return mask;
    endfunction

    function automatic logic [31:0] exc_target(input logic [31:0] exc_type, input logic [31:0] epc,
                                               input logic [31:0] exc_vec, input logic [31:0] int_vec);
        logic [31:0] target;
        case (exc_type)
            EXC_INT:                                         target = int_vec;
            EXC_SYSCALL, EXC_BREAK, EXC_RI, EXC_OV, EXC_TRAP: target = exc_vec;
            EXC_ERET:                                        target = epc;
            default:                                         target = exc_vec;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall/flush control bundle between the pipeline control unit (master) and the pipeline (slave).
interface pipeline_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    modport master (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
        output stall, flush, new_pc, stall_timeout, stall_cycles, flush_count
    );

    modport slave (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
        input  stall, flush, new_pc, stall_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Consecutive-stall watchdog: counts stalled cycles and raises a sticky flag
// once STALL_TIMEOUT consecutive stalls have been seen.
module stall_watchdog #(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    input  logic flush,
    output logic timeout
);
    localparam int unsigned CW = $clog2(STALL_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(STALL_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r;
    logic          timeout_r;

    // Consecutive-stall counter; parks at CNT_MAX instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || flush || !stall_active) begin
            cnt_r <= '0;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Sticky flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_r <= 1'b0;
        end else if (stall_active && (cnt_r == CNT_MAX)) begin
            timeout_r <= 1'b1;
        end
    end

    assign timeout = timeout_r;
endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline control: stall arbitration, exception flush/redirect,
// post-flush FSM and health counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR      = 32'h0000_0040,
    parameter logic [31:0] INT_VECTOR      = 32'h0000_0020,
    parameter int unsigned STALL_TIMEOUT   = 1024,
    parameter logic [15:0] FLUSH_COUNT_MAX = 16'hFFFF
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.master bus
);
    ctrl_state_e state_r;
    ctrl_state_e state_next_s;
    logic [5:0]  stall_req_s;
    logic [5:0]  stall_s;
    logic        flush_s;
    logic [31:0] new_pc_s;
    logic [31:0] stall_cycles_r;
    logic [15:0] flush_count_r;
    logic        timeout_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; FLUSHED always returns to RUN after one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush_s) begin
                    state_next_s = ST_FLUSHED;
                end else if (stall_s != STALL_NONE) begin
                    state_next_s = ST_STALLED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STALLED: begin
                if (flush_s) begin
                    state_next_s = ST_FLUSHED;
                end else if (stall_s == STALL_NONE) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_STALLED;
                end
            end
            ST_FLUSHED: state_next_s = ST_RUN;
            default:    state_next_s = ST_RUN;
        endcase
    end

    // Control outputs; the exception beats any stall, and the FLUSHED cycle masks both.
    always_comb begin
        stall_req_s = stall_arbitrate(bus.stallreq_if, bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem);
        stall_s     = STALL_NONE;
        flush_s     = 1'b0;
        new_pc_s    = 32'h0000_0000;
        if (rst) begin
            stall_s = STALL_NONE;
        end else if (state_r == ST_FLUSHED) begin
            stall_s = STALL_NONE;
        end else if (bus.excepttype != EXC_NONE) begin
            flush_s  = 1'b1;
            new_pc_s = exc_target(bus.excepttype, bus.cp0_epc, EXC_VECTOR, INT_VECTOR);
        end else begin
            stall_s = stall_req_s;
        end
    end

    // Stalled-cycle counter, free-running with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r <= 32'h0000_0000;
        end else if (stall_s != STALL_NONE) begin
            stall_cycles_r <= stall_cycles_r + 32'h0000_0001;
        end
    end

    // Flush counter, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_count_r <= 16'h0000;
        end else if (flush_s && (flush_count_r != FLUSH_COUNT_MAX)) begin
            flush_count_r <= flush_count_r + 16'h0001;
        end
    end

    stall_watchdog #(.STALL_TIMEOUT(STALL_TIMEOUT)) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .stall_active (stall_s != STALL_NONE),
        .flush        (flush_s),
        .timeout      (timeout_s)
    );

    assign bus.stall         = stall_s;
    assign bus.flush         = flush_s;
    assign bus.new_pc        = new_pc_s;
    assign bus.stall_timeout = timeout_s;
    assign bus.stall_cycles  = stall_cycles_r;
    assign bus.flush_count   = flush_count_r;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: priority, exceptions, watchdog,
// reset mid-stall and flush-counter saturation (on a second, small-limit instance).
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if bus();
    pipeline_ctrl_if sat_bus();

    pipeline_ctrl #(
        .EXC_VECTOR(32'h0000_0040), .INT_VECTOR(32'h0000_0020), .STALL_TIMEOUT(8)
    ) dut (.clk(clk), .rst(rst), .bus(bus.master));

    pipeline_ctrl #(
        .STALL_TIMEOUT(8), .FLUSH_COUNT_MAX(16'd20)
    ) dut_sat (.clk(clk), .rst(rst), .bus(sat_bus.master));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem);
        bus.stallreq_if  = r_if;
        bus.stallreq_id  = r_id;
        bus.stallreq_ex  = r_ex;
        bus.stallreq_mem = r_mem;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.excepttype = 32'h8;
        bus.cp0_epc    = 32'h0;
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        sat_bus.stallreq_if = 1'b0; sat_bus.stallreq_id = 1'b0;
        sat_bus.stallreq_ex = 1'b0; sat_bus.stallreq_mem = 1'b0;
        sat_bus.excepttype = 32'h0; sat_bus.cp0_epc = 32'h0;
        tick(); tick();
        // Reset gates outputs even with requests and an exception present
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        chk("rst_newpc", bus.new_pc, 32'h0);
        chk("rst_scyc", bus.stall_cycles, 32'h0);
        chk("rst_fcnt", 32'(bus.flush_count), 32'h0);
        chk("rst_tmo", 32'(bus.stall_timeout), 32'h0);

        rst = 1'b0;
        bus.excepttype = 32'h0;
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_stall", 32'(bus.stall), 32'h0);
        tick();

        // Stall priority
        set_req(1'b0, 1'b1, 1'b1, 1'b0); chk("id_ex", 32'(bus.stall), 32'h0F); tick();
        set_req(1'b0, 1'b1, 1'b0, 1'b0); chk("id",    32'(bus.stall), 32'h07); tick();
        set_req(1'b0, 1'b0, 1'b0, 1'b0); chk("none",  32'(bus.stall), 32'h00);
        chk("scyc_2", bus.stall_cycles, 32'd2); tick();
        set_req(1'b1, 1'b0, 1'b0, 1'b0); chk("if",     32'(bus.stall), 32'h03); tick();
        set_req(1'b1, 1'b0, 1'b0, 1'b1); chk("if_mem", 32'(bus.stall), 32'h1F); tick();
        set_req(1'b0, 1'b0, 1'b0, 1'b0); chk("drop",   32'(bus.stall), 32'h00);
        chk("scyc_4", bus.stall_cycles, 32'd4); tick();

        // Exception with MEM stall: flush wins
        bus.excepttype = 32'h8;
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        chk("exc_flush", 32'(bus.flush), 32'h1);
        chk("exc_stall", 32'(bus.stall), 32'h0);
        chk("exc_newpc", bus.new_pc, 32'h40);
        tick();
        // FLUSHED cycle ignores both the repeated exception and the request
        chk("fl_flush", 32'(bus.flush), 32'h0);
        chk("fl_stall", 32'(bus.stall), 32'h0);
        chk("fl_newpc", bus.new_pc, 32'h0);
        chk("fcnt_1", 32'(bus.flush_count), 32'd1);
        tick();
        bus.excepttype = 32'h0; #1;
        chk("post_fl_stall", 32'(bus.stall), 32'h1F);
        chk("fcnt_1b", 32'(bus.flush_count), 32'd1);
        tick();

        // eret taken from STALLED
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        bus.cp0_epc = 32'h0000_1234;
        bus.excepttype = 32'he; #1;
        chk("eret_flush", 32'(bus.flush), 32'h1);
        chk("eret_newpc", bus.new_pc, 32'h1234);
        tick();
        bus.excepttype = 32'h0; #1;
        chk("eret_fl", 32'(bus.flush), 32'h0);
        tick();
        bus.excepttype = 32'h1; #1;
        chk("int_newpc", bus.new_pc, 32'h20); tick();
        bus.excepttype = 32'h0; tick();
        bus.excepttype = 32'h4; #1;
        chk("other_newpc", bus.new_pc, 32'h40); tick();
        bus.excepttype = 32'h0; tick();
        bus.excepttype = 32'hc; #1;
        chk("ov_newpc", bus.new_pc, 32'h40); tick();
        bus.excepttype = 32'h0; tick();
        chk("fcnt_5", 32'(bus.flush_count), 32'd5);
        chk("scyc_5", bus.stall_cycles, 32'd5);

        // Watchdog: flag appears after exactly 8 stalled cycles
        set_req(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("wd_low", 32'(bus.stall_timeout), 32'h0);
            tick();
        end
        chk("wd_high", 32'(bus.stall_timeout), 32'h1);
        chk("wd_scyc", bus.stall_cycles, 32'd13);
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chk("wd_sticky", 32'(bus.stall_timeout), 32'h1);

        // Reset in the middle of a MEM stall
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        tick(); tick();
        rst = 1'b1;
        bus.excepttype = 32'h8; #1;
        chk("mrst_stall", 32'(bus.stall), 32'h0);
        chk("mrst_flush", 32'(bus.flush), 32'h0);
        chk("mrst_newpc", bus.new_pc, 32'h0);
        tick();
        rst = 1'b0;
        bus.excepttype = 32'h0; #1;
        chk("mrst_scyc", bus.stall_cycles, 32'h0);
        chk("mrst_fcnt", 32'(bus.flush_count), 32'h0);
        chk("mrst_tmo", 32'(bus.stall_timeout), 32'h0);
        chk("mrst_run_stall", 32'(bus.stall), 32'h1F);
        tick();
        chk("mrst_scyc_1", bus.stall_cycles, 32'd1);
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        bus.excepttype = 32'h8; #1;
        chk("mrst_exc", 32'(bus.flush), 32'h1);
        tick();
        bus.excepttype = 32'h0;
        chk("mrst_fcnt_1", 32'(bus.flush_count), 32'd1);

        // Saturation on the small-limit instance: one flush every two cycles
        sat_bus.excepttype = 32'h8;
        for (int i = 0; i < 38; i++) tick();
        chk("sat_19", 32'(sat_bus.flush_count), 32'd19);
        tick(); tick();
        chk("sat_20", 32'(sat_bus.flush_count), 32'd20);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_hold", 32'(sat_bus.flush_count), 32'd20);
        sat_bus.excepttype = 32'h0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
